addsub_serial: RTL and testbench
================================

# addsub_serial

Parametrised digit-serial two's-complement adder/subtractor: one WIDTH-bit add or subtract takes WIDTH/DIGIT clock cycles, processing DIGIT bits per cycle, LSB digit first. It extends the 4-bit ripple adder-cum-subtractor in three ways: arbitrary width, a start/busy/done handshake, and registered results with carry and signed-overflow flags. It sits in the datapath wherever a wide add/sub is needed and area matters more than latency.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- Derived: NDIG = WIDTH/DIGIT (cycles per operation).
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled with an accepted start.
- b  input  WIDTH  operand B; sampled with an accepted start.
- m  input  1  mode: 0 = A+B, 1 = A−B. Sampled with an accepted start.
- busy  output  1  high while an operation is in progress (RUN).
- done  output  1  one-cycle pulse marking a new result.
- s  output  WIDTH  result, registered.
- c_out  output  1  carry out of the MSB. For subtract, 1 means no borrow (A ≥ B unsigned).
- v  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN.
- **IDLE, start=1 at an edge:**
  - Latch a into the A working register.
  - Latch b XOR {WIDTH{m}} into the B working register.
  - Load carry register = m and digit counter = 0.
  - Go to RUN.
- **IDLE, start=0:** hold state.
- **RUN, each edge:**
  - Add digit k of A, digit k of B and the carry register (DIGIT-bit add).
  - Write the sum into slice k of the internal sum register; write the digit carry-out into the carry register.
  - Increment the counter.
- **Last digit (k = NDIG−1):**
  - Also capture the carry into bit WIDTH−1.
  - Copy the full sum to s, the final carry to c_out, and the XOR of the MSB carries to v.
  - Assert done; return to IDLE.
- s, c_out and v change only at the completion edge. They hold their value until the next completion.
- start during RUN is ignored; the operands and mode of the accepted operation are unaffected.
- a, b and m may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH; no saturation.
- DIGIT = WIDTH gives single-cycle operation (NDIG = 1) through the same FSM.

## Timing
- **Reset (rst_n low, asynchronous):**
  - state = IDLE; counter = 0; working registers = 0.
  - busy = 0, done = 0, s = 0, c_out = 0, v = 0.
  - An operation in flight is aborted without done.
  - Normal operation resumes on the first edge after rst_n deasserts.
- **Latency:** start accepted at edge t0. busy is high from just after t0 through edge t(NDIG).
- **Completion:** done is high for exactly the cycle after edge t(NDIG), with the new s/c_out/v valid in that same cycle. busy is low in that cycle.
- **Back-to-back:** start held high in the done cycle is accepted at the next edge. Sustained throughput is one result per NDIG+1 cycles.
- done never asserts for two consecutive cycles.
- busy and done are never high together.

## Test plan
- **Basic add:** WIDTH=16, DIGIT=4. Start with a=0x000B, b=0x000D, m=0 → done exactly 4 cycles after the accepting edge; s=0x0018, c_out=0, v=0; busy high for 4 cycles.
- **Overflow:** a=0x7FFF, b=0x0001, m=0 → s=0x8000, c_out=0, v=1. Then a=0x8000, b=0x0001, m=1 → s=0x7FFF, c_out=1, v=1.
- **Subtract and borrow:**
  - a=0x000B, b=0x000D, m=1 → s=0xFFFE, c_out=0, v=0.
  - a=0x0000, b=0xFFFF, m=1 → s=0x0001, c_out=0, v=0.
- **Parameter corner:** WIDTH=4, DIGIT=1. a=4'b1011, b=4'b1101, m=0 → s=4'b1000, c_out=1, v=0 after 4 cycles. Same operands with m=1 → s=4'b1110, c_out=0, v=0. Also run WIDTH=16, DIGIT=16 and check single-cycle latency.
- **Handshake:**
  - Pulse start again mid-RUN with different operands → ignored; result is from the first operands.
  - Hold start high through the done cycle → second operation accepted immediately; done pulses are NDIG+1 cycles apart.
- **Reset mid-run:** drop rst_n two cycles after start → all outputs 0 immediately, no done pulse. After release, a new start gives the correct result.

Source files
------------

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement adder/subtractor.
//
// One WIDTH-bit A+B or A-B is processed DIGIT bits per clock, least
// significant digit first. An operation takes NDIG = WIDTH/DIGIT cycles.
// Subtraction is done as A + ~B + 1: B is inverted on capture and the
// carry register is preloaded with the mode bit.
//
// Parameters:
//   WIDTH  operand/result width (multiple of DIGIT)
//   DIGIT  bits processed per cycle (1..WIDTH)
//
// Ports:
//   clk    clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   start  request, sampled only while idle
//   a, b   operands, captured with an accepted start
//   m      mode (0 = A+B, 1 = A-B), captured with an accepted start
//   busy   high while an operation is in progress
//   done   one-cycle pulse marking a new result on s/c_out/v
//   s      registered result
//   c_out  carry out of the MSB (for subtract: 1 = no borrow)
//   v      signed overflow flag
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             v
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [DIGIT-1:0] sum_dig_reg [NDIG];
  logic [WIDTH-1:0] s_reg;
  logic             c_out_reg;
  logic             v_reg;
  logic             done_reg;

  logic [DIGIT-1:0] a_dig [NDIG];
  logic [DIGIT-1:0] b_dig [NDIG];
  logic [DIGIT-1:0] a_cur;
  logic [DIGIT-1:0] b_cur;
  logic [DIGIT:0]   dig_add;
  logic             msb_carry_in;
  logic             last_dig;
  logic [WIDTH-1:0] sum_full;

  // Split the working registers into digit slices for the digit mux.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      assign a_dig[gi] = a_reg[gi*DIGIT +: DIGIT];
      assign b_dig[gi] = b_reg[gi*DIGIT +: DIGIT];
    end
  endgenerate

  assign a_cur   = a_dig[cnt_reg];
  assign b_cur   = b_dig[cnt_reg];
  assign dig_add = {1'b0, a_cur} + {1'b0, b_cur} + {{DIGIT{1'b0}}, carry_reg};

  // The sum bit is a ^ b ^ carry_in, so the carry into the top bit of
  // the digit can be recovered without a second adder. Only meaningful
  // on the last digit, where that bit is the result MSB.
  assign msb_carry_in = a_cur[DIGIT-1] ^ b_cur[DIGIT-1] ^ dig_add[DIGIT-1];

  assign last_dig = (state_reg == RUN) && (cnt_reg == LAST_DIG);

  // Full result on the completion edge: earlier digits from the sum
  // register, top digit straight from the adder.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_sum
      if (gi == NDIG - 1) begin : g_top
        assign sum_full[gi*DIGIT +: DIGIT] = dig_add[DIGIT-1:0];
      end else begin : g_low
        assign sum_full[gi*DIGIT +: DIGIT] = sum_dig_reg[gi];
      end
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == LAST_DIG) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        sum_dig_reg[i] <= '0;
      end
      s_reg     <= '0;
      c_out_reg <= 1'b0;
      v_reg     <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE) begin
        if (start) begin
          a_reg     <= a;
          b_reg     <= b ^ {WIDTH{m}};
          carry_reg <= m;
          cnt_reg   <= '0;
        end
      end else begin
        sum_dig_reg[cnt_reg] <= dig_add[DIGIT-1:0];
        carry_reg            <= dig_add[DIGIT];
        cnt_reg              <= last_dig ? '0 : cnt_reg + 1'b1;
        if (last_dig) begin
          s_reg     <= sum_full;
          c_out_reg <= dig_add[DIGIT];
          v_reg     <= msb_carry_in ^ dig_add[DIGIT];
          done_reg  <= 1'b1;
        end
      end
    end
  end

  assign busy  = (state_reg == RUN);
  assign done  = done_reg;
  assign s     = s_reg;
  assign c_out = c_out_reg;
  assign v     = v_reg;

endmodule

// File: tb/tb_addsub_serial.sv
// Testbench for addsub_serial: three instances (16/4, 4/1, 16/16) driven
// by directed vectors. An arithmetic reference model predicts every
// output each cycle; directed steps also check hand-computed results.
module tb_addsub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  start_v;
  logic [2:0]  m_v;
  logic [15:0] a_v [3];
  logic [15:0] b_v [3];
  logic [2:0]  busy_o, done_o, c_o, v_o;
  logic [15:0] s0, s2;
  logic [3:0]  s1;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  int ndig [3] = '{4, 4, 1};
  int wid  [3] = '{16, 4, 16};

  addsub_serial #(.WIDTH(16), .DIGIT(4)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .m(m_v[0]),
    .busy(busy_o[0]), .done(done_o[0]), .s(s0), .c_out(c_o[0]), .v(v_o[0]));

  addsub_serial #(.WIDTH(4), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1][3:0]), .b(b_v[1][3:0]), .m(m_v[1]),
    .busy(busy_o[1]), .done(done_o[1]), .s(s1), .c_out(c_o[1]), .v(v_o[1]));

  addsub_serial #(.WIDTH(16), .DIGIT(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .m(m_v[2]),
    .busy(busy_o[2]), .done(done_o[2]), .s(s2), .c_out(c_o[2]), .v(v_o[2]));

  function automatic logic [15:0] get_s(input int i);
    case (i)
      0:       return s0;
      1:       return {12'b0, s1};
      default: return s2;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain integer arithmetic reference for a w-bit add/subtract.
  task automatic ref_calc(input int w, input logic [15:0] a, input logic [15:0] b, input logic m,
                          output logic [15:0] rs, output logic rc, output logic rv);
    longint md, ua, ub, sa, sb, r, res;
    md  = longint'(1) << w;
    ua  = longint'(a) % md;
    ub  = longint'(b) % md;
    sa  = (ua >= md / 2) ? ua - md : ua;
    sb  = (ub >= md / 2) ? ub - md : ub;
    if (m) begin
      r   = ua - ub;
      rc  = (ua >= ub);
      res = sa - sb;
    end else begin
      r   = ua + ub;
      rc  = (r >= md);
      res = sa + sb;
    end
    r  = ((r % md) + md) % md;
    rs = 16'(r);
    rv = (res < -(md / 2)) || (res >= md / 2);
  endtask

  // Reference model: cycles remaining per instance, pending result
  int          left [3] = '{0, 0, 0};
  logic        exp_done [3] = '{0, 0, 0};
  logic [15:0] exp_s [3] = '{0, 0, 0};
  logic        exp_c [3] = '{0, 0, 0};
  logic        exp_v [3] = '{0, 0, 0};
  logic [15:0] pend_s [3];
  logic        pend_c [3];
  logic        pend_v [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        left[i] = 0; exp_done[i] = 1'b0;
        exp_s[i] = '0; exp_c[i] = 1'b0; exp_v[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp_done[i] = 1'b0;
        if (left[i] > 0) begin
          left[i]--;
          if (left[i] == 0) begin
            exp_done[i] = 1'b1;
            exp_s[i] = pend_s[i]; exp_c[i] = pend_c[i]; exp_v[i] = pend_v[i];
          end
        end else if (start_v[i]) begin
          left[i] = ndig[i];
          ref_calc(wid[i], a_v[i], b_v[i], m_v[i], pend_s[i], pend_c[i], pend_v[i]);
        end
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cyc busy%0d", i), 16'(busy_o[i]), 16'(left[i] != 0));
      check($sformatf("cyc done%0d", i), 16'(done_o[i]), 16'(exp_done[i]));
      check($sformatf("cyc s%0d", i), get_s(i), exp_s[i]);
      check($sformatf("cyc c_out%0d", i), 16'(c_o[i]), 16'(exp_c[i]));
      check($sformatf("cyc v%0d", i), 16'(v_o[i]), 16'(exp_v[i]));
    end
  end

  // Count negedges until done on instance i, bounded.
  task automatic wait_done(input int i, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done_o[i] && k < 60);
    if (!done_o[i]) check($sformatf("timeout done%0d", i), 16'(done_o[i]), 16'd1);
  endtask

  task automatic check_result(input string tag, input int i, input logic [15:0] es,
                              input logic ec, input logic ev);
    check({tag, " s"}, get_s(i), es);
    check({tag, " c_out"}, 16'(c_o[i]), 16'(ec));
    check({tag, " v"}, 16'(v_o[i]), 16'(ev));
    $display("op %s: dut%0d s=%h c_out=%0b v=%0b", tag, i, get_s(i), c_o[i], v_o[i]);
  endtask

  task automatic run_op(input string tag, input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic m, input logic [15:0] es, input logic ec, input logic ev);
    int k;
    @(posedge clk); #1;
    start_v[i] = 1'b1; a_v[i] = a; b_v[i] = b; m_v[i] = m;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    a_v[i] = 16'($urandom); b_v[i] = 16'($urandom); m_v[i] = 1'($urandom);
    wait_done(i, k);
    check({tag, " latency"}, 16'(k - 1), 16'(ndig[i]));
    check_result(tag, i, es, ec, ev);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start_v = '0; m_v = '0;
    for (int i = 0; i < 3; i++) begin a_v[i] = '0; b_v[i] = '0; end
    repeat (2) @(negedge clk);
    check("reset s0", s0, 16'h0000);
    check("reset busy", 16'(busy_o), 16'h0);
    rst_n = 1'b1;

    run_op("add_b_d",    0, 16'h000B, 16'h000D, 1'b0, 16'h0018, 1'b0, 1'b0);
    run_op("ovf_add",    0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_sub",    0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_b_d",    0, 16'h000B, 16'h000D, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_0_ffff", 0, 16'h0000, 16'hFFFF, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_op("w4_add",     1, 16'h000B, 16'h000D, 1'b0, 16'h0008, 1'b1, 1'b0);
    run_op("w4_sub",     1, 16'h000B, 16'h000D, 1'b1, 16'h000E, 1'b0, 1'b0);
    run_op("d16_add",    2, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("d16_sub",    2, 16'h1234, 16'h0235, 1'b1, 16'h0FFF, 1'b1, 1'b0);

    // start pulsed mid-run is ignored
    @(posedge clk); #1;
    start_v[0] = 1'b1; a_v[0] = 16'h0100; b_v[0] = 16'h0023; m_v[0] = 1'b0;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    start_v[0] = 1'b1; a_v[0] = 16'hFFFF; b_v[0] = 16'hFFFF; m_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, k);
    check_result("midrun", 0, 16'h0123, 1'b0, 1'b0);
    repeat (8) @(posedge clk);

    // start held through the done cycle: back-to-back
    @(posedge clk); #1;
    start_v[0] = 1'b1; a_v[0] = 16'h1234; b_v[0] = 16'h1111; m_v[0] = 1'b0;
    @(posedge clk); #1;
    a_v[0] = 16'h9000; b_v[0] = 16'h1000; m_v[0] = 1'b1;
    wait_done(0, k);
    check_result("b2b_1", 0, 16'h2345, 1'b0, 1'b0);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, k);
    check("b2b spacing", 16'(k), 16'(ndig[0] + 1));
    check_result("b2b_2", 0, 16'h8000, 1'b1, 1'b0);

    // reset two cycles into a run
    @(posedge clk); #1;
    start_v[0] = 1'b1; a_v[0] = 16'h1111; b_v[0] = 16'h2222; m_v[0] = 1'b0;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst busy", 16'(busy_o), 16'h0);
    check("rst done", 16'(done_o), 16'h0);
    check("rst s0", s0, 16'h0000);
    check("rst s1", {12'b0, s1}, 16'h0000);
    check("rst s2", s2, 16'h0000);
    check("rst flags", {8'b0, 1'b0, c_o, 1'b0, v_o}, 16'h0000);
    $display("op reset: busy=%b s0=%h s2=%h", busy_o, s0, s2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    run_op("post_rst", 0, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
